bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
Downstream consumer of the 12-bit, 3-digit packed BCD value produced by the team's BCD incrementor/counter path. Time-multiplexes the three digits onto one shared active-low 7-segment bus with per-digit active-low anode enables. Latches the input once per frame so the display never shows digits from two different values. Includes anode blanking between digit slots to suppress ghosting.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range is 2 or more.
BLANK_CYCLES, 16, cycles at the end of each slot with all anodes off; legal range is 0 to REFRESH_DIV-1.

Ports:
clk  input  1  system clock; the block uses this single clock only.
rst  input  1  asynchronous, active-high reset.
bcd_in  input  12  packed BCD value: [11:8] hundreds, [7:4] tens, [3:0] units.
seg  output  7  segment drive {g,f,e,d,c,b,a}; active-low.
an  output  3  digit anode enables; active-low; an[0] is units, an[2] is hundreds.
frame_tick  output  1  one-cycle pulse, one cycle after each input latch.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk):
  - prescaler = 0, digit index = 0, latched value = 12'h000.
  - seg = 7'h7F, an = 3'b111, frame_tick = 0.
- Prescaler:
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle (prescaler = REFRESH_DIV-1) is the slot end.
- Digit index sequence:
  - 0 -> 1 -> 2 -> 0, advancing on slot end only.
  - Index value 3 is unreachable; if it ever occurs, the next cycle forces index to 0.
- Input latch:
  - On the slot end where the index goes 2 -> 0, bcd_in is sampled into the latched value.
  - frame_tick is high for exactly the following cycle.
  - bcd_in changes at any other time have no visible effect until the next frame.
- Output registers (one cycle of latency from index/prescaler/latched value):
  - seg = decode(latched nibble selected by index).
  - an = one-hot-low on the current index while prescaler < REFRESH_DIV-BLANK_CYCLES; otherwise 3'b111.
  - With BLANK_CYCLES = 0, an is never all-off during the scan.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD nibbles 10-15 show a dash: 0111111.
- No other timing dependence on bcd_in; the block is a pure sink with no backpressure.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). Scanning restarts at index 0 with the latched value 000. The first real sample of bcd_in is taken at the end of the first full frame after reset release.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Hundreds digit anode is held off when its latched nibble = 0.
  - Tens digit anode is held off when both the hundreds and tens nibbles = 0.
  - Units digit is never blanked.
  - seg is still driven normally during a blanked slot; only the anode is forced high.
- Undefined: all three digits are always shown, including leading zeros.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the seg7 code constants for 0-9, dash and all-off (7'h7F);
  - the digit-index type (2 bits);
  - the constant NUM_DIGITS = 3.
- One sub-module: bcd_to_seg7, a combinational 4-bit nibble to 7-bit active-low decoder, reusable by other display blocks.
- The prescaler, index, latch and output registers stay in the top module.

Test Plan:
Bench settings: REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset: assert rst mid-slot -> seg=7'h7F, an=3'b111 and frame_tick=0 in the same cycle; after release, the first slot shows an=3'b110 with seg=1000000 (digit 0).
2. bcd_in=12'h159 held: per frame, the units slot shows seg=0010000 on an=110, tens shows 0010010 on an=101, hundreds shows 1111001 on an=011. Anodes are active for 6 cycles and off for 2 cycles per slot. frame_tick pulses every 24 cycles.
3. Change bcd_in from 12'h159 to 12'h160 mid-frame -> the remaining slots of that frame still show 159; the new value appears only after the next frame_tick.
4. bcd_in=12'h0A7 -> the tens slot shows the dash (0111111); the hundreds slot shows 1000000.
5. With LEADING_ZERO_BLANK_EN defined, bcd_in=12'h005 -> the hundreds and tens slots keep an=111 for the whole slot; the units slot shows 0010010. With bcd_in=12'h000, only the units slot is shown, as 0.
6. BLANK_CYCLES=0, REFRESH_DIV=2 -> an walks 110, 110, 101, 101, 011, 011 with no all-off cycles, and index wraps correctly.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// ============================================================================
//  Module   : bcd_disp_pkg
//  Purpose  : Shared 7-segment codes and digit-index type for BCD display blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

  localparam int NUM_DIGITS = 3;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t c_idx_last = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0    = 7'b1000000;
  localparam logic [6:0] c_seg_1    = 7'b1111001;
  localparam logic [6:0] c_seg_2    = 7'b0100100;
  localparam logic [6:0] c_seg_3    = 7'b0110000;
  localparam logic [6:0] c_seg_4    = 7'b0011001;
  localparam logic [6:0] c_seg_5    = 7'b0010010;
  localparam logic [6:0] c_seg_6    = 7'b0000010;
  localparam logic [6:0] c_seg_7    = 7'b1111000;
  localparam logic [6:0] c_seg_8    = 7'b0000000;
  localparam logic [6:0] c_seg_9    = 7'b0010000;
  localparam logic [6:0] c_seg_dash = 7'b0111111;
  localparam logic [6:0] c_seg_off  = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD nibble to active-low 7-segment decoder;
//             non-BCD codes 10-15 show a dash.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = c_seg_dash;
    case (nibble)
      4'd0:    seg = c_seg_0;
      4'd1:    seg = c_seg_1;
      4'd2:    seg = c_seg_2;
      4'd3:    seg = c_seg_3;
      4'd4:    seg = c_seg_4;
      4'd5:    seg = c_seg_5;
      4'd6:    seg = c_seg_6;
      4'd7:    seg = c_seg_7;
      4'd8:    seg = c_seg_8;
      4'd9:    seg = c_seg_9;
      default: seg = c_seg_dash;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// ============================================================================
//  Module   : bcd_display_scanner
//  Purpose  : Time-multiplexes a 3-digit packed BCD value onto one active-low
//             7-segment bus with per-slot anode blanking. Optional macro
//             LEADING_ZERO_BLANK_EN suppresses leading-zero digit anodes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_tick
);

  // One spare bit so REFRESH_DIV-BLANK_CYCLES is representable even at BLANK_CYCLES=0
  localparam int               c_pw        = $clog2(REFRESH_DIV + 1);
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(REFRESH_DIV - 1);
  localparam logic [c_pw-1:0] c_an_on_lim = c_pw'(REFRESH_DIV - BLANK_CYCLES);

  logic [c_pw-1:0] r_presc;
  digit_idx_t      r_idx;
  logic [11:0]     r_latched;

  logic            w_slot_end;
  logic            w_frame_end;
  logic [3:0]      w_nibble;
  logic [2:0]      w_an_sel;
  logic [6:0]      w_seg;
  logic            w_an_active;
  logic            w_lz_blank;

  assign w_slot_end  = (r_presc == c_presc_max);
  assign w_frame_end = w_slot_end && (r_idx == c_idx_last);
  assign w_an_active = (r_presc < c_an_on_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_latched <= 12'h000;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (r_idx > c_idx_last)
        r_idx <= '0;
      else if (w_slot_end)
        r_idx <= (r_idx == c_idx_last) ? digit_idx_t'(0) : r_idx + 1'b1;
      // Sampling only at the frame boundary keeps all three digits coherent
      if (w_frame_end)
        r_latched <= bcd_in;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_an_sel = 3'b111;
    case (r_idx)
      2'd0: begin w_nibble = r_latched[3:0];  w_an_sel = 3'b110; end
      2'd1: begin w_nibble = r_latched[7:4];  w_an_sel = 3'b101; end
      2'd2: begin w_nibble = r_latched[11:8]; w_an_sel = 3'b011; end
      default: begin w_nibble = 4'h0;         w_an_sel = 3'b111; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = ((r_idx == 2'd2) && (r_latched[11:8] == 4'h0)) ||
                      ((r_idx == 2'd1) && (r_latched[11:4] == 8'h00));
`else
  assign w_lz_blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= c_seg_off;
      an         <= 3'b111;
      frame_tick <= 1'b0;
    end else begin
      seg        <= w_seg;
      an         <= (w_an_active && !w_lz_blank) ? w_an_sel : 3'b111;
      frame_tick <= w_frame_end;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
//  Module   : tb_bcd_display_scanner
//  Purpose  : Scoreboard bench for bcd_display_scanner at two parameter sets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bcd_display_scanner;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };
  localparam logic [10:0] RST_OUT = {7'h7F, 3'b111, 1'b0};

  logic        clk;
  logic        rst;
  logic [11:0] bcd_in;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  an_a, an_b;
  logic        ft_a, ft_b;

  int          n_checks;
  int          n_fail;

  bcd_display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .bcd_in(bcd_in),
    .seg(seg_a), .an(an_a), .frame_tick(ft_a)
  );

  bcd_display_scanner #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .bcd_in(bcd_in),
    .seg(seg_b), .an(an_b), .frame_tick(ft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seg, an, frame_tick} visible after the k-th clock edge since reset
  // release, given the value shown in the current frame.
  function automatic logic [10:0] expect_out(int k, logic [11:0] lat, int div, int blank);
    int          frame;
    int          d;
    int          pos;
    logic [11:0] sh;
    logic [6:0]  s;
    logic [2:0]  a;
    logic        f;
    frame = 3 * div;
    d     = (k / div) % 3;
    pos   = k % div;
    sh    = lat >> (4 * d);
    s     = SEG_TAB[sh[3:0]];
    a     = 3'b111;
    if (pos < div - blank) a[d] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && lat[11:8] == 4'h0) a = 3'b111;
    if (d == 1 && lat[11:4] == 8'h00) a = 3'b111;
`endif
    f = (k % frame == frame - 1);
    return {s, a, f};
  endfunction

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got seg=%b an=%b ft=%b, expected seg=%b an=%b ft=%b",
               name, $time, act[10:4], act[3:1], act[0], exp[10:4], exp[3:1], exp[0]);
    end
  endtask

  // Reference model: pushes the expected output for every clock edge
  int          k_a, k_b;
  logic [11:0] lat_a, lat_b;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always @(posedge clk) begin
    if (rst) begin
      k_a = 0; lat_a = 12'h000; q_a.delete();
      k_b = 0; lat_b = 12'h000; q_b.delete();
    end else begin
      q_a.push_back(expect_out(k_a, lat_a, 8, 2));
      if (k_a % 24 == 23) lat_a = bcd_in;
      k_a++;
      q_b.push_back(expect_out(k_b, lat_b, 2, 0));
      if (k_b % 6 == 5) lat_b = bcd_in;
      k_b++;
    end
  end

  // Monitor: compares on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      check("reset_a", {seg_a, an_a, ft_a}, RST_OUT);
      check("reset_b", {seg_b, an_b, ft_b}, RST_OUT);
    end else begin
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("scan_a", {seg_a, an_a, ft_a}, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("scan_b", {seg_b, an_b, ft_b}, e);
      end
    end
  end

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bcd_in   = 12'h000;
    hold(3);
    rst = 1'b0;

    bcd_in = 12'h159;
    hold(60);
    // Mid-frame change: must only appear after the next frame boundary
    bcd_in = 12'h160;
    hold(50);

    // Asynchronous reset in the middle of a slot
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", {seg_a, an_a, ft_a}, RST_OUT);
    check("async_rst_b", {seg_b, an_b, ft_b}, RST_OUT);
    hold(2);
    rst = 1'b0;

    bcd_in = 12'h0A7;
    hold(60);
    bcd_in = 12'h005;
    hold(60);
    bcd_in = 12'h000;
    hold(60);
    bcd_in = 12'h999;
    hold(30);

    repeat (40) begin
      bcd_in = 12'($urandom_range(0, 4095));
      hold(int'($urandom_range(1, 40)));
    end

    hold(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
